// File: rtl/gpu_ctrl_axil_regfile_if.sv
// AXI4-Lite bus bundle between the PS interconnect (master) and the GPU control register file (slave).
// Ports: AW/W/B write channels and AR/R read channels, widths set by ADDR_W and DATA_W.
interface gpu_ctrl_axil_regfile_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input  rready
    );

    modport master (
        output awaddr, awprot, awvalid, input  awready,
        output wdata, wstrb, wvalid,    input  wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input  arready,
        input  rdata, rresp, rvalid,    output rready
    );
endinterface

// File: rtl/gpu_ctrl_axil_regfile.sv
// AXI4-Lite slave register file for the GPU control path.
// Control registers (low indices) are read/write with byte strobes and a one-cycle write pulse each;
// status registers (top indices) are read-only views of status_in; other addresses answer SLVERR.
// Ports: ACLK, ARESET (sync, active-high), s_axi (AXI4-Lite slave), ctrl_out (flat control regs),
//        ctrl_wr_pulse (per control register), status_in (flat status inputs).
module gpu_ctrl_axil_regfile #(
    parameter int unsigned             C_DATA_WIDTH = 32,
    parameter int unsigned             C_ADDR_WIDTH = 8,
    parameter int unsigned             C_NUM_REGS   = 8,
    parameter int unsigned             C_NUM_STATUS = 2,
    parameter logic [C_DATA_WIDTH-1:0] C_RESET_VAL  = '0
) (
    input  logic                                                        ACLK,
    input  logic                                                        ARESET,
    gpu_ctrl_axil_regfile_if.slave                                      s_axi,
    output logic [(C_NUM_REGS-C_NUM_STATUS)*C_DATA_WIDTH-1:0]           ctrl_out,
    output logic [C_NUM_REGS-C_NUM_STATUS-1:0]                          ctrl_wr_pulse,
    input  logic [((C_NUM_STATUS > 0) ? C_NUM_STATUS : 1)*C_DATA_WIDTH-1:0] status_in
);
    localparam int unsigned B   = C_DATA_WIDTH / 8;
    localparam int unsigned LSB = $clog2(B);
    localparam int unsigned IW  = C_ADDR_WIDTH - LSB;
    localparam int unsigned NC  = C_NUM_REGS - C_NUM_STATUS;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    // Write holding registers
    logic                    aw_held_q, aw_held_d;
    logic [IW-1:0]           aw_idx_q,  aw_idx_d;
    logic                    w_held_q,  w_held_d;
    logic [C_DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [B-1:0]            wstrb_q,   wstrb_d;
    // Response channels
    logic                    bvalid_q,  bvalid_d;
    logic [1:0]              bresp_q,   bresp_d;
    logic                    rvalid_q,  rvalid_d;
    logic [1:0]              rresp_q,   rresp_d;
    logic [C_DATA_WIDTH-1:0] rdata_q,   rdata_d;
    // Register storage
    logic [C_DATA_WIDTH-1:0] ctrl_q [NC];
    logic [C_DATA_WIDTH-1:0] ctrl_d [NC];
    logic [NC-1:0]           pulse_q,   pulse_d;

    logic          commit_c;
    logic [IW-1:0] ar_idx_c;

    assign commit_c = aw_held_q && w_held_q && !bvalid_q;
    assign ar_idx_c = s_axi.araddr[C_ADDR_WIDTH-1:LSB];

    // Next-state logic for write capture/commit and read response
    always_comb begin
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        ctrl_d    = ctrl_q;
        pulse_d   = '0;

        // AW and W capture independently; still allowed while BVALID waits
        if (s_axi.awvalid && !aw_held_q) begin
            aw_held_d = 1'b1;
            aw_idx_d  = s_axi.awaddr[C_ADDR_WIDTH-1:LSB];
        end
        if (s_axi.wvalid && !w_held_q) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi.wdata;
            wstrb_d  = s_axi.wstrb;
        end

        if (bvalid_q && s_axi.bready) begin
            bvalid_d = 1'b0;
        end

        // Commit only when both halves are held and no response is outstanding
        if (commit_c) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = RESP_SLVERR;
            for (int unsigned i = 0; i < NC; i++) begin
                if (32'(aw_idx_q) == i) begin
                    bresp_d    = RESP_OKAY;
                    pulse_d[i] = 1'b1;
                    for (int unsigned b = 0; b < B; b++) begin
                        if (wstrb_q[b]) begin
                            ctrl_d[i][b*8 +: 8] = wdata_q[b*8 +: 8];
                        end
                    end
                end
            end
        end

        // Read uses ctrl_q, so a same-edge commit returns the pre-write value
        if (s_axi.arvalid && !rvalid_q) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_SLVERR;
            for (int unsigned i = 0; i < NC; i++) begin
                if (32'(ar_idx_c) == i) begin
                    rdata_d = ctrl_q[i];
                    rresp_d = RESP_OKAY;
                end
            end
            for (int unsigned j = 0; j < C_NUM_STATUS; j++) begin
                if (32'(ar_idx_c) == NC + j) begin
                    rdata_d = status_in[j*C_DATA_WIDTH +: C_DATA_WIDTH];
                    rresp_d = RESP_OKAY;
                end
            end
        end else if (rvalid_q && s_axi.rready) begin
            rvalid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; reset drops any in-flight transaction
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            pulse_q   <= '0;
            for (int unsigned i = 0; i < NC; i++) begin
                ctrl_q[i] <= C_RESET_VAL;
            end
        end else begin
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            pulse_q   <= pulse_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign s_axi.awready = !aw_held_q;
    assign s_axi.wready  = !w_held_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = !rvalid_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;
    assign ctrl_wr_pulse = pulse_q;

    for (genvar g = 0; g < NC; g++) begin : g_ctrl_out
        assign ctrl_out[g*C_DATA_WIDTH +: C_DATA_WIDTH] = ctrl_q[g];
    end

    // Protection bits and sub-word address bits carry no meaning here
    logic unused_ok;
    assign unused_ok = ^{s_axi.awprot, s_axi.arprot,
                         s_axi.awaddr[LSB-1:0], s_axi.araddr[LSB-1:0]};
endmodule

// File: tb/tb_gpu_ctrl_axil_regfile.sv
// Scoreboard bench for gpu_ctrl_axil_regfile: expected B/R beats are queued when stimulus is issued
// and compared when the DUT raises BVALID/RVALID.
module tb_gpu_ctrl_axil_regfile;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;
    localparam int unsigned NR = 8;
    localparam int unsigned NS = 2;
    localparam int unsigned NC = NR - NS;
    localparam logic [31:0] RST_VAL = 32'h0000_5A5A;
    localparam logic [1:0]  OKAY    = 2'b00;
    localparam logic [1:0]  SLVERR  = 2'b10;

    typedef struct { logic [1:0] resp; logic [NC-1:0] pulse; } b_exp_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; } r_exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gpu_ctrl_axil_regfile_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();
    logic [NC*DW-1:0] ctrl_out;
    logic [NC-1:0]    pulse;
    logic [NS*DW-1:0] status_in;

    gpu_ctrl_axil_regfile #(
        .C_DATA_WIDTH(DW), .C_ADDR_WIDTH(AW), .C_NUM_REGS(NR),
        .C_NUM_STATUS(NS), .C_RESET_VAL(RST_VAL)
    ) dut (
        .ACLK(clk), .ARESET(rst), .s_axi(axi.slave),
        .ctrl_out(ctrl_out), .ctrl_wr_pulse(pulse), .status_in(status_in)
    );

    int checks = 0;
    int errors = 0;
    b_exp_t b_q [$];
    r_exp_t r_q [$];
    logic [31:0] mdl [NC];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Monitors: compare on the first cycle of each BVALID / RVALID
    logic   bv_prev = 1'b0;
    logic   rv_prev = 1'b0;
    int     neg_cnt = 0;
    int     last_bhs = 0;
    int     last_gap = 0;
    int     b_rises = 0;
    b_exp_t be;
    r_exp_t re;

    always @(negedge clk) begin
        neg_cnt++;
        if (axi.bvalid && !bv_prev) begin
            b_rises++;
            last_gap = neg_cnt - last_bhs;
            if (b_q.size() == 0) begin
                check_eq("b_unexpected", 64'(axi.bvalid), 64'(0));
            end else begin
                be = b_q.pop_front();
                check_eq("bresp", 64'(axi.bresp), 64'(be.resp));
                check_eq("wr_pulse", 64'(pulse), 64'(be.pulse));
            end
        end else if (pulse != '0) begin
            check_eq("stray_pulse", 64'(pulse), 64'(0));
        end
        if (axi.bvalid && axi.bready) last_bhs = neg_cnt;
        bv_prev = axi.bvalid;

        if (axi.rvalid && !rv_prev) begin
            if (r_q.size() == 0) begin
                check_eq("r_unexpected", 64'(axi.rvalid), 64'(0));
            end else begin
                re = r_q.pop_front();
                check_eq("rdata", 64'(axi.rdata), 64'(re.data));
                check_eq("rresp", 64'(axi.rresp), 64'(re.resp));
            end
        end
        rv_prev = axi.rvalid;
    end

    task automatic send_aw(input logic [7:0] addr);
        int n = 0;
        axi.awaddr  = addr;
        axi.awvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!axi.awready && n < 50);
        if (!axi.awready) check_eq("aw_timeout", 64'(axi.awready), 64'(1));
        @(posedge clk); #1;
        axi.awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        axi.wdata  = data;
        axi.wstrb  = strb;
        axi.wvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!axi.wready && n < 50);
        if (!axi.wready) check_eq("w_timeout", 64'(axi.wready), 64'(1));
        @(posedge clk); #1;
        axi.wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [7:0] addr);
        int n = 0;
        axi.araddr  = addr;
        axi.arvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!axi.arready && n < 50);
        if (!axi.arready) check_eq("ar_timeout", 64'(axi.arready), 64'(1));
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
    endtask

    // Updates the shadow model, queues the expected response, then drives AW and W
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit w_first);
        int idx = int'(addr >> 2);
        b_exp_t e;
        if (idx < int'(NC)) begin
            for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][b*8 +: 8] = data[b*8 +: 8];
            e.resp  = OKAY;
            e.pulse = NC'(1) << idx;
        end else begin
            e.resp  = SLVERR;
            e.pulse = '0;
        end
        b_q.push_back(e);
        if (w_first) begin
            fork
                send_w(data, strb);
                begin @(posedge clk); #1; send_aw(addr); end
            join
        end else begin
            fork
                send_aw(addr);
                send_w(data, strb);
            join
        end
    endtask

    task automatic axi_read(input logic [7:0] addr, input logic [31:0] data, input logic [1:0] resp);
        r_exp_t e;
        e.data = data;
        e.resp = resp;
        r_q.push_back(e);
        send_ar(addr);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end
        while ((b_q.size() != 0 || r_q.size() != 0 || axi.bvalid || axi.rvalid) && n < 100);
        if (b_q.size() != 0 || r_q.size() != 0)
            check_eq("idle_timeout", 64'(b_q.size() + r_q.size()), 64'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    int rises_base;

    initial begin
        rst = 1'b1;
        axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
        axi.wdata = '0;  axi.wstrb = '0;  axi.wvalid = 1'b0;
        axi.bready = 1'b1;
        axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0;
        axi.rready = 1'b1;
        status_in = {32'hCAFE_0001, 32'hBEEF_0000};
        for (int i = 0; i < int'(NC); i++) mdl[i] = RST_VAL;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_awready", 64'(axi.awready), 64'(1));
        check_eq("rst_wready",  64'(axi.wready),  64'(1));
        check_eq("rst_arready", 64'(axi.arready), 64'(1));
        check_eq("rst_bvalid",  64'(axi.bvalid),  64'(0));
        check_eq("rst_rvalid",  64'(axi.rvalid),  64'(0));
        check_eq("rst_pulse",   64'(pulse),       64'(0));
        for (int i = 0; i < int'(NC); i++)
            check_eq("rst_ctrl_out", 64'(ctrl_out[i*32 +: 32]), 64'(RST_VAL));
        @(posedge clk); #1;

        // Sequential write / readback
        for (int i = 0; i < 4; i++) axi_write(8'(i * 4), 32'(i + 1), 4'hF, 1'b0);
        wait_idle();
        for (int i = 0; i < 4; i++) axi_read(8'(i * 4), 32'(i + 1), OKAY);
        wait_idle();
        for (int i = 0; i < int'(NC); i++)
            check_eq("ctrl_out", 64'(ctrl_out[i*32 +: 32]), 64'(mdl[i]));

        // Byte strobes
        axi_write(8'h00, 32'hFFFF_FFFF, 4'hF, 1'b0);
        axi_write(8'h00, 32'h1234_5678, 4'b0101, 1'b0);
        wait_idle();
        axi_read(8'h00, 32'hFF34_FF78, OKAY);
        wait_idle();

        // Status registers and error responses
        axi_read(8'h18, 32'hBEEF_0000, OKAY);
        axi_read(8'h1C, 32'hCAFE_0001, OKAY);
        axi_write(8'h18, 32'hDEAD_BEEF, 4'hF, 1'b0);
        axi_read(8'h20, 32'h0, SLVERR);
        axi_write(8'h20, 32'h1111_1111, 4'hF, 1'b0);
        axi_read(8'h14, mdl[5], OKAY);
        wait_idle();

        // Ordering and backpressure
        axi.bready = 1'b0;
        rises_base = b_rises;
        axi_write(8'h00, 32'hA1A1_0001, 4'hF, 1'b1);
        axi_write(8'h04, 32'hB2B2_0002, 4'hF, 1'b0);
        repeat (5) @(negedge clk);
        check_eq("bp_one_bvalid", 64'(b_rises - rises_base), 64'(1));
        check_eq("bp_bvalid_held", 64'(axi.bvalid), 64'(1));
        check_eq("bp_ctrl1_old", 64'(ctrl_out[32 +: 32]), 64'(32'h2));
        @(posedge clk); #1;
        axi.bready = 1'b1;
        wait_idle();
        check_eq("bp_two_bvalid", 64'(b_rises - rises_base), 64'(2));
        check_eq("bp_commit_gap", 64'(last_gap), 64'(2));
        axi_read(8'h00, 32'hA1A1_0001, OKAY);
        axi_read(8'h04, 32'hB2B2_0002, OKAY);
        wait_idle();

        // Same-edge read and commit to 0x8 sees the old value
        fork
            axi_write(8'h08, 32'd9, 4'hF, 1'b0);
            begin @(posedge clk); #1; axi_read(8'h08, 32'd3, OKAY); end
        join
        wait_idle();
        axi_read(8'h08, 32'd9, OKAY);
        wait_idle();

        // Reset with a held AW and a pending RVALID
        axi.rready = 1'b0;
        axi_read(8'h00, mdl[0], OKAY);
        send_aw(8'h04);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst2_bvalid",  64'(axi.bvalid),  64'(0));
        check_eq("rst2_rvalid",  64'(axi.rvalid),  64'(0));
        check_eq("rst2_awready", 64'(axi.awready), 64'(1));
        check_eq("rst2_arready", 64'(axi.arready), 64'(1));
        @(posedge clk); #1;
        axi.rready = 1'b1;
        for (int i = 0; i < int'(NC); i++) mdl[i] = RST_VAL;
        for (int i = 0; i < int'(NC); i++) axi_read(8'(i * 4), RST_VAL, OKAY);
        wait_idle();
        axi_write(8'h04, 32'h0BAD_F00D, 4'hF, 1'b0);
        wait_idle();
        axi_read(8'h04, 32'h0BAD_F00D, OKAY);
        wait_idle();
        check_eq("final_ctrl1", 64'(ctrl_out[32 +: 32]), 64'(32'h0BAD_F00D));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gpu_ctrl_axil_regfile.md
# gpu_ctrl_axil_regfile

Parametrised AXI4-Lite slave register file for the GPU control path; the next generation of the fixed four-register gpu_control slave. It provides a configurable number of read/write control registers, read-only status registers, byte-strobe writes, per-register write pulses and SLVERR signalling for bad accesses. It sits between the PS AXI interconnect and the GPU core's control and status nets.

## Interface
- C_DATA_WIDTH, 32: AXI data and register width; 32 or 64.
- C_ADDR_WIDTH, 8: AXI address width; must satisfy 2^C_ADDR_WIDTH ≥ C_NUM_REGS·C_DATA_WIDTH/8.
- C_NUM_REGS, 8: total register count (control + status); 2..64.
- C_NUM_STATUS, 2: read-only status registers, occupying the top indices; 0..C_NUM_REGS-1.
- C_RESET_VAL, 0: reset value of every control register.

Let B = C_DATA_WIDTH/8 and NC = C_NUM_REGS-C_NUM_STATUS.

- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous reset, active-high.
- S_AXI_AWADDR  in  C_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake.
- S_AXI_WDATA  in  C_DATA_WIDTH  write data.
- S_AXI_WSTRB  in  B  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake.
- S_AXI_BRESP  out  2  OKAY 2'b00 or SLVERR 2'b10.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake.
- S_AXI_ARADDR  in  C_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake.
- S_AXI_RDATA  out  C_DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake.
- ctrl_out  out  NC·C_DATA_WIDTH  control registers, flat; register i at [i·C_DATA_WIDTH +: C_DATA_WIDTH].
- ctrl_wr_pulse  out  NC  one-cycle pulse per committed control-register write.
- status_in  in  C_NUM_STATUS·C_DATA_WIDTH  status inputs; status index j maps to register NC+j.

## Operation
- Decode: idx = addr[C_ADDR_WIDTH-1 : log2(B)]. Low log2(B) bits are ignored.
- Write channel:
  - AW and W are accepted independently, in either order, each into a one-deep holding register.
  - AWREADY = !aw_held. WREADY = !w_held.
  - Commit occurs on the edge where aw_held && w_held && !BVALID.
- Commit behaviour:
  - If idx < NC: for each byte b with WSTRB[b]=1, update that byte of register idx. Set BRESP=OKAY and pulse ctrl_wr_pulse[idx], even when WSTRB=0.
  - If idx ≥ NC (status register or unmapped): no update, no pulse, BRESP=SLVERR.
  - In all cases: clear aw_held and w_held, assert BVALID.
- BVALID and BRESP hold until BREADY. While BVALID is high, no new commit occurs; AW and W may still be captured into their holding registers.
- Read channel:
  - ARREADY = !RVALID.
  - On an AR handshake, RDATA and RRESP are registered and RVALID asserts.
  - idx < NC: control register, OKAY.
  - NC ≤ idx < C_NUM_REGS: status_in sampled at the AR handshake edge, OKAY.
  - Otherwise: RDATA=0, SLVERR.
  - RDATA, RRESP and RVALID hold until RREADY.
- Read and write paths are independent. A read and a commit to the same register on the same edge return the pre-write value.
- ctrl_out is driven directly from the control registers and reflects a write in the cycle after the commit edge.

## Timing
- Reset (ARESET high at an edge):
  - Control registers = C_RESET_VAL.
  - Holding registers cleared.
  - BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0, ctrl_wr_pulse=0.
  - AWREADY=WREADY=ARREADY=1 from the first cycle after reset.
  - An in-flight transaction is dropped without a response.
  - While ARESET is high, the READY outputs are still driven from the cleared state; handshakes in that cycle are discarded.
- Write latency: AW and W handshake on edge k → commit, BVALID, ctrl_out update and ctrl_wr_pulse all on edge k+1. Pulse width is exactly 1 cycle.
- Write throughput with BREADY held high: one write per 2 cycles.
- Read latency: AR handshake on edge k → RVALID on edge k. Throughput with RREADY held high: one read per 2 cycles.
- Backpressure: with BREADY low, a second AW/W pair is captured but waits. Its commit occurs on the edge after the B handshake.

## Test plan
- Sequential write/readback (32-bit, 8 registers, 2 status): write 1,2,3,4 to 0x0,0x4,0x8,0xC → four OKAY responses, reads return 1,2,3,4, ctrl_wr_pulse pulses bits 0..3 once each.
- Strobe: write 0xFFFFFFFF to 0x0, then 0x12345678 with WSTRB=4'b0101 → reading 0x0 returns 0xFF34FF78.
- Status and error: status_in = {32'hCAFE0001, 32'hBEEF0000}.
  - Read 0x18 → 0xBEEF0000 OKAY.
  - Read 0x1C → 0xCAFE0001 OKAY.
  - Write 0x18 → SLVERR, no pulse.
  - Read 0x20 → 0, SLVERR.
- Ordering and backpressure: W one cycle before AW, with BREADY low for 5 cycles, then a second write to 0x4 issued.
  - Exactly one BVALID is held.
  - The second write commits on the edge after the B handshake.
  - Both values read back.
- Same-edge read and write to 0x8 (old 3, new 9) → read returns 3, next read returns 9.
- ARESET asserted for 1 cycle while a write is held and a read has RVALID pending → all VALIDs drop, control registers read C_RESET_VAL, and the next transactions complete normally.
